iram_load_controller: RTL and testbench

Sequences the loading of the CPU instruction RAM from an external byte stream and arbitrates the instruction RAM address port between the loader and the CPU fetch path. It holds the CPU until a complete program has been written, then hands the address port to the CPU. It sits between the boot/debug byte source, the CPU program counter and the instruction RAM write/read port.

---
 rtl/iram_load_pkg.sv | 27 ++
 rtl/iram_load_controller_if.sv | 32 +++
 rtl/iram_byte_assembler.sv | 33 +++
 rtl/iram_load_controller.sv | 148 ++++++++++++++
 tb/tb_iram_load_controller.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/iram_load_pkg.sv
// Shared types and stream-format constants for the instruction RAM loader.
// No ports: state enum, header/word byte counts, byte_ready state decode.
package iram_load_pkg;

   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;
   localparam int CNT_W          = HDR_BYTES * 8;
   localparam int BCNT_W         = $clog2(BYTES_PER_WORD);
   localparam int SR_W           = 8 * (BYTES_PER_WORD - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR_HI,
      S_HDR_LO,
      S_PAYLOAD,
      S_WRITE,
      S_CHECK,
      S_RUN,
      S_ERROR
   } state_t;

   // States in which the loader takes a byte from the stream.
   function automatic logic takes_byte(state_t s);
      return s inside {S_HDR_HI, S_HDR_LO, S_PAYLOAD, S_CHECK};
   endfunction

endpackage

// File: rtl/iram_load_controller_if.sv
// Byte stream, CPU fetch address and instruction RAM port bundle.
// master: byte source / CPU side; slave: the load controller.
interface iram_load_controller_if #(
   parameter int ADDR_W = 10
);
   logic              load_start;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic [ADDR_W-1:0] cpu_address;
   logic [ADDR_W-1:0] iram_address;
   logic              iram_write_en;
   logic [31:0]       iram_write_data;
   logic              cpu_hold;
   logic              load_done;
   logic              load_error;
   logic [ADDR_W:0]   words_loaded;

   modport master (
      output load_start, byte_valid, byte_data, cpu_address,
      input  byte_ready, iram_address, iram_write_en,
      input  iram_write_data, cpu_hold, load_done,
      input  load_error, words_loaded
   );

   modport slave (
      input  load_start, byte_valid, byte_data, cpu_address,
      output byte_ready, iram_address, iram_write_en,
      output iram_write_data, cpu_hold, load_done,
      output load_error, words_loaded
   );
endinterface

// File: rtl/iram_byte_assembler.sv
// Packs big-endian stream bytes into 32-bit words.
// Ports: clock, clear, shift_en, byte_in -> word, word_valid.
module iram_byte_assembler
   import iram_load_pkg::*;
(
   input  logic        clock,
   input  logic        clear,
   input  logic        shift_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [SR_W-1:0]   sr;
   logic [BCNT_W-1:0] cnt;

   always_ff @(posedge clock) begin
      if (clear) begin
         sr  <= '0;
         cnt <= '0;
      end else if (shift_en) begin
         sr  <= {sr[SR_W-9:0], byte_in};
         cnt <= cnt + BCNT_W'(1);
      end
   end

   // Last byte of a word is presented directly, so the word is
   // complete in the same cycle it is accepted.
   assign word_valid = shift_en &&
                       (cnt == BCNT_W'(BYTES_PER_WORD - 1));
   assign word = {sr, byte_in};

endmodule

// File: rtl/iram_load_controller.sv
// Loads the instruction RAM from a byte stream, then hands the RAM
// address port to the CPU. Ports: clock, reset, bus (slave modport).
// Optional IRAM_LOAD_CHECKSUM_EN adds a trailing XOR checksum byte.
module iram_load_controller
   import iram_load_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int WORDS  = 1024
) (
   input  logic                   clock,
   input  logic                   reset,
   iram_load_controller_if.slave  bus
);

`ifdef IRAM_LOAD_CHECKSUM_EN
   localparam state_t FIN = S_CHECK;
`else
   localparam state_t FIN = S_RUN;
`endif

   state_t            state;
   logic [CNT_W-1:0]  n_words;
   logic [CNT_W-1:0]  hdr_n;
   logic [ADDR_W-1:0] waddr;
   logic [ADDR_W:0]   wl;
   logic [ADDR_W:0]   wl_nx;
   logic              acc;
   logic              wv;
   logic [31:0]       word;
   logic              hold;
   logic              done;
   logic              err;
   logic              we;
   logic [31:0]       wdata;

   // load_start wins: no byte is consumed in the restart cycle.
   assign bus.byte_ready   = !bus.load_start && takes_byte(state);
   assign acc              = bus.byte_valid && bus.byte_ready;
   assign bus.iram_address = (state == S_RUN) ? bus.cpu_address
                                              : waddr;

   assign bus.iram_write_en   = we;
   assign bus.iram_write_data = wdata;
   assign bus.cpu_hold        = hold;
   assign bus.load_done       = done;
   assign bus.load_error      = err;
   assign bus.words_loaded    = wl;

   assign hdr_n = {n_words[CNT_W-1:8], bus.byte_data};
   assign wl_nx = wl + (ADDR_W + 1)'(1);

   iram_byte_assembler u_asm (
      .clock      (clock),
      .clear      (reset || bus.load_start),
      .shift_en   (acc && (state == S_PAYLOAD)),
      .byte_in    (bus.byte_data),
      .word       (word),
      .word_valid (wv)
   );

`ifdef IRAM_LOAD_CHECKSUM_EN
   logic [7:0] csum;

   always_ff @(posedge clock) begin
      if (reset || bus.load_start)
         csum <= '0;
      else if (acc && (state != S_CHECK))
         csum <= csum ^ bus.byte_data;
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= S_IDLE;
         n_words <= '0;
         waddr   <= '0;
         wl      <= '0;
         hold    <= 1'b1;
         done    <= 1'b0;
         err     <= 1'b0;
         we      <= 1'b0;
         wdata   <= '0;
      end else if (bus.load_start) begin
         state <= S_HDR_HI;
         waddr <= '0;
         wl    <= '0;
         hold  <= 1'b1;
         done  <= 1'b0;
         err   <= 1'b0;
         we    <= 1'b0;
      end else begin
         unique case (state)
            S_HDR_HI: if (acc) begin
               n_words <= {bus.byte_data, 8'h00};
               state   <= S_HDR_LO;
            end
            S_HDR_LO: if (acc) begin
               n_words <= hdr_n;
               if (hdr_n == '0) begin
                  state <= FIN;
                  if (FIN == S_RUN) begin
                     hold <= 1'b0;
                     done <= 1'b1;
                  end
               end else if (hdr_n > CNT_W'(WORDS)) begin
                  state <= S_ERROR;
                  err   <= 1'b1;
               end else begin
                  state <= S_PAYLOAD;
               end
            end
            S_PAYLOAD: if (acc && wv) begin
               state <= S_WRITE;
               we    <= 1'b1;
               wdata <= word;
            end
            S_WRITE: begin
               we    <= 1'b0;
               waddr <= waddr + ADDR_W'(1);
               wl    <= wl_nx;
               if (CNT_W'(wl_nx) == n_words) begin
                  state <= FIN;
                  if (FIN == S_RUN) begin
                     hold <= 1'b0;
                     done <= 1'b1;
                  end
               end else begin
                  state <= S_PAYLOAD;
               end
            end
`ifdef IRAM_LOAD_CHECKSUM_EN
            S_CHECK: if (acc) begin
               if (bus.byte_data == csum) begin
                  state <= S_RUN;
                  hold  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state <= S_ERROR;
                  err   <= 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iram_load_controller.sv
// Self-checking bench for iram_load_controller: RAM writes are
// predicted into a scoreboard queue and popped as the DUT writes.
module tb_iram_load_controller;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   iram_load_controller_if bus ();

   iram_load_controller dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

`ifdef IRAM_LOAD_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t0    = 0;
   int lat;
   logic [41:0]  sb[$];
   logic [7:0]   strm[$];
   logic [31:0]  wq[$];
   logic [7:0]   cs;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   always @(negedge clock) begin : mon
      logic [41:0] e;
      if (!reset && bus.iram_write_en) begin
         if (sb.size() == 0) begin
            check("wr_unexpected", 1, 0);
         end else begin
            e = sb.pop_front();
            check("wr_addr", bus.iram_address, e[41:32]);
            check("wr_data", bus.iram_write_data, e[31:0]);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic pb(input logic [7:0] b);
      strm.push_back(b);
      cs ^= b;
   endtask

   task automatic build(input int n, input bit push, input bit bad_cs);
      strm.delete();
      cs = 8'h00;
      pb(n[15:8]);
      pb(n[7:0]);
      foreach (wq[i]) begin
         pb(wq[i][31:24]);
         pb(wq[i][23:16]);
         pb(wq[i][15:8]);
         pb(wq[i][7:0]);
         if (push) sb.push_back({10'(i), wq[i]});
      end
      if (CS != 0) strm.push_back(bad_cs ? ~cs : cs);
   endtask

   task automatic pulse_start();
      bus.load_start = 1'b1;
      step();
      bus.load_start = 1'b0;
      t0 = cyc;
   endtask

   task automatic send(input bit gaps);
      int i = 0;
      int guard = 0;
      while (i < strm.size() && guard < 20000) begin
         bus.byte_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         bus.byte_data  = strm[i];
         @(negedge clock);
         if (bus.byte_valid && bus.byte_ready) i++;
         step();
         guard++;
      end
      bus.byte_valid = 1'b0;
      if (i < strm.size()) check("send_timeout", i, strm.size());
   endtask

   task automatic wait_done();
      for (int g = 0; g < 2000; g++) begin
         @(negedge clock);
         if (bus.load_done) break;
      end
      check("done_wait", bus.load_done, 1);
      lat = cyc - t0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: no finish");
      $fatal(1);
   end

   initial begin
      int acc_cnt;
      reset           = 1'b1;
      bus.load_start  = 1'b0;
      bus.byte_valid  = 1'b0;
      bus.byte_data   = 8'h00;
      bus.cpu_address = 10'h155;
      step();
      step();
      check("rst_ready", bus.byte_ready, 0);
      check("rst_we", bus.iram_write_en, 0);
      check("rst_wdata", bus.iram_write_data, 0);
      check("rst_addr", bus.iram_address, 0);
      check("rst_hold", bus.cpu_hold, 1);
      check("rst_done", bus.load_done, 0);
      check("rst_err", bus.load_error, 0);
      check("rst_wl", bus.words_loaded, 0);
      reset = 1'b0;
      step();
      check("idle_ready", bus.byte_ready, 0);

      // N=2 reference program
      wq = '{32'h016C0000, 32'h55400000};
      build(2, 1, 0);
      pulse_start();
      send(0);
      wait_done();
      check("n2_latency", lat, 12 + CS);
      check("n2_wl", bus.words_loaded, 2);
      check("n2_hold", bus.cpu_hold, 0);
      check("n2_err", bus.load_error, 0);
      check("n2_ready", bus.byte_ready, 0);
      check("n2_mux_a", bus.iram_address, 10'h155);
      bus.cpu_address = 10'h3FF;
      #1;
      check("n2_mux_b", bus.iram_address, 10'h3FF);
      step();

      // N=0: straight to run, no writes
      wq.delete();
      build(0, 1, 0);
      pulse_start();
      send(0);
      wait_done();
      check("n0_latency", lat, 2 + CS);
      check("n0_wl", bus.words_loaded, 0);
      check("n0_hold", bus.cpu_hold, 0);
      step();

      // N=1025: oversize header
      wq.delete();
      build(1025, 0, 0);
      while (strm.size() > 2) void'(strm.pop_back());
      pulse_start();
      send(0);
      check("big_err", bus.load_error, 1);
      check("big_hold", bus.cpu_hold, 1);
      check("big_done", bus.load_done, 0);
      acc_cnt = 0;
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'h5A;
      repeat (8) begin
         @(negedge clock);
         if (bus.byte_ready) acc_cnt++;
         step();
      end
      bus.byte_valid = 1'b0;
      check("big_ignored", acc_cnt, 0);
      check("big_err_hold", bus.load_error, 1);
      check("big_iaddr", bus.iram_address, 0);

      // N=3 gap-free then same program with random gaps
      wq.delete();
      for (int k = 0; k < 3; k++) wq.push_back($urandom);
      build(3, 1, 0);
      pulse_start();
      send(0);
      wait_done();
      check("n3_latency", lat, 17 + CS);
      check("n3_wl", bus.words_loaded, 3);
      step();
      build(3, 1, 0);
      pulse_start();
      send(1);
      wait_done();
      check("gap_wl", bus.words_loaded, 3);
      check("gap_hold", bus.cpu_hold, 0);
      step();

      // restart after one word of an N=4 load
      wq.delete();
      for (int k = 0; k < 4; k++) wq.push_back($urandom);
      build(4, 0, 0);
      sb.push_back({10'd0, wq[0]});
      while (strm.size() > 6) void'(strm.pop_back());
      pulse_start();
      send(0);
      step();
      check("rs_wl1", bus.words_loaded, 1);
      bus.load_start = 1'b1;
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'hAA;
      @(negedge clock);
      check("rs_ready", bus.byte_ready, 0);
      step();
      bus.load_start = 1'b0;
      bus.byte_valid = 1'b0;
      t0 = cyc;
      check("rs_wl0", bus.words_loaded, 0);
      wq = '{32'hDEADBEEF};
      build(1, 1, 0);
      send(0);
      wait_done();
      check("rs_lat", lat, 7 + CS);
      check("rs_wl", bus.words_loaded, 1);
      step();

      // reset in the middle of a payload word
      wq = '{32'h11223344, 32'h55667788};
      build(2, 0, 0);
      while (strm.size() > 4) void'(strm.pop_back());
      pulse_start();
      send(0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mr_ready", bus.byte_ready, 0);
      check("mr_we", bus.iram_write_en, 0);
      check("mr_wdata", bus.iram_write_data, 0);
      check("mr_addr", bus.iram_address, 0);
      check("mr_hold", bus.cpu_hold, 1);
      check("mr_done", bus.load_done, 0);
      check("mr_err", bus.load_error, 0);
      check("mr_wl", bus.words_loaded, 0);
      step();

`ifdef IRAM_LOAD_CHECKSUM_EN
      wq = '{32'h12345678};
      build(1, 1, 1);
      pulse_start();
      send(0);
      step();
      check("cs_err", bus.load_error, 1);
      check("cs_hold", bus.cpu_hold, 1);
      check("cs_done", bus.load_done, 0);
`endif

      step();
      check("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
